// File: rtl/eight_organizer_control_row_if.sv
// eight_organizer_control_row_if
// Bundles every non-clock/reset signal of the reduction back end.
//   slave  : the organizer block (consumes packages, demux and FIFO requests).
//   master : the controller / driver side.
// Signals:
//   demux_in/demux_select -> demux_out          half-package steering
//   package_in/package_valid/adder_tree_start   package reduction request
//   sum_out/final_adder_finish/tree_finish      accumulator results
//   fifo_write_* / fifo_read_address -> fifo_read_data   multiples store
interface eight_organizer_control_row_if #(
  parameter int unsigned no_of_units   = 8,
  parameter int unsigned element_width = 32
);
  logic [element_width*no_of_units/2-1:0] demux_in;
  logic                                   demux_select;
  logic [element_width*no_of_units-1:0]   demux_out;
  logic [element_width*no_of_units-1:0]   package_in;
  logic                                   package_valid;
  logic                                   adder_tree_start;
  logic [31:0]                            sum_out;
  logic                                   final_adder_finish;
  logic                                   tree_finish;
  logic                                   fifo_write_enable;
  logic [12:0]                            fifo_write_address;
  logic [12:0]                            fifo_read_address;
  logic [31:0]                            fifo_write_data;
  logic [31:0]                            fifo_read_data;

  modport slave (
    input  demux_in, demux_select, package_in, package_valid, adder_tree_start,
           fifo_write_enable, fifo_write_address, fifo_read_address, fifo_write_data,
    output demux_out, sum_out, final_adder_finish, tree_finish, fifo_read_data
  );

  modport master (
    output demux_in, demux_select, package_in, package_valid, adder_tree_start,
           fifo_write_enable, fifo_write_address, fifo_read_address, fifo_write_data,
    input  demux_out, sum_out, final_adder_finish, tree_finish, fifo_read_data
  );
endinterface

// File: rtl/eight_organizer_control_row.sv
// eight_organizer_control_row
// Reduction back end of the 8-lane dot-product unit:
//   - demux: places a half-width multiplier result in the upper or lower half of a package
//   - organizer: registered input stage, log2(N)-level pipelined FP32 adder tree, then a
//     running accumulator (sum_out) with finish pulses
//   - multiples store: fifo_depth x 32 addressed memory, sync write, comb read
// Ports: clk, reset (sync, active-high), bus (eight_organizer_control_row_if.slave).
// Build option: ORGANIZER_ROUND_NEAREST_EN selects round-to-nearest-even in every FP add;
// otherwise results truncate toward zero. Latency is the same in both builds.
module eight_organizer_control_row #(
  parameter int unsigned no_of_units   = 8,
  parameter int unsigned element_width = 32,
  parameter int unsigned fifo_depth    = 10
) (
  input logic                          clk,
  input logic                          reset,
  eight_organizer_control_row_if.slave bus
);

  localparam int unsigned Levels = $clog2(no_of_units);
  localparam int unsigned Nodes  = no_of_units - 1;
  localparam int unsigned Aw     = $clog2(fifo_depth);
  localparam logic [12:0] DepthA = 13'(fifo_depth);

  // Single-precision add with flush-to-zero, saturation and canonical NaN.
  // The smaller significand is aligned inside a 50-bit field, so the raw sum is exact and
  // only the final normalisation decides truncation or rounding.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, t;
    logic [7:0]  diff;
    logic [49:0] ma, mb;
    logic [50:0] s, norm;
    logic [22:0] man;
    int          p, e;
`ifdef ORGANIZER_ROUND_NEAREST_EN
    logic [23:0] man_r;
    logic        guard, sticky;
`endif
    a = (x[30:23] == 8'h00) ? {x[31], 31'b0} : x;
    b = (y[30:23] == 8'h00) ? {y[31], 31'b0} : y;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return 32'h7FC0_0000;
    if (a[30:0] < b[30:0]) begin
      t = a;
      a = b;
      b = t;
    end
    if (a[30:0] == 31'b0) return 32'h0;
    if (b[30:0] == 31'b0) return a;
    diff = a[30:23] - b[30:23];
    if (diff > 8'd24) return a;
    ma = {1'b1, a[22:0], 26'b0};
    mb = {1'b1, b[22:0], 26'b0} >> diff;
    s  = (a[31] == b[31]) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
    if (s == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 51; i++) begin
      if (s[i]) p = i;
    end
    norm = s << (50 - p);
    man  = norm[49:27];
    e    = int'(a[30:23]) + p - 49;
`ifdef ORGANIZER_ROUND_NEAREST_EN
    guard  = norm[26];
    sticky = |norm[25:0];
    man_r  = {1'b0, man} + {23'b0, guard & (sticky | man[0])};
    if (man_r[23]) begin
      e   = e + 1;
      man = 23'b0;
    end else begin
      man = man_r[22:0];
    end
`endif
    if (e >= 255) return {a[31], 8'hff, 23'b0};
    if (e <= 0) return {a[31], 31'b0};
    return {a[31], e[7:0], man};
  endfunction

  // Demux
  always_comb begin
    if (bus.demux_select) begin
      bus.demux_out = {{(element_width*no_of_units/2){1'b0}}, bus.demux_in};
    end else begin
      bus.demux_out = {bus.demux_in, {(element_width*no_of_units/2){1'b0}}};
    end
  end

  // Input stage and adder tree
  logic [element_width*no_of_units-1:0] pkg_q;
  logic                                 in_vld_q;
  logic [31:0]                          lane [no_of_units];
  logic [31:0]                          node_q [Nodes];
  logic [31:0]                          node_d [Nodes];
  logic [Levels-1:0]                    vld_q;
  logic [Levels:0]                      vld_shift;

  // Lane 0 is the most significant element of the package.
  for (genvar i = 0; i < no_of_units; i++) begin : g_lane
    assign lane[i] = pkg_q[element_width*(no_of_units-i)-1 -: 32];
  end

  // Nodes of level k live at [no_of_units - (no_of_units >> k) +: no_of_units >> (k+1)].
  for (genvar k = 0; k < Levels; k++) begin : g_lvl
    localparam int unsigned Off = no_of_units - (no_of_units >> k);
    for (genvar j = 0; j < (no_of_units >> (k + 1)); j++) begin : g_node
      if (k == 0) begin : g_leaf
        assign node_d[j] = fp_add(lane[2*j], lane[2*j+1]);
      end else begin : g_inner
        localparam int unsigned PrevOff = no_of_units - (no_of_units >> (k - 1));
        assign node_d[Off+j] = fp_add(node_q[PrevOff+2*j], node_q[PrevOff+2*j+1]);
      end
    end
  end

  assign vld_shift = {vld_q, in_vld_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      pkg_q    <= '0;
      in_vld_q <= 1'b0;
      vld_q    <= '0;
      node_q   <= '{default: '0};
    end else begin
      pkg_q    <= bus.package_in;
      in_vld_q <= bus.package_valid & bus.adder_tree_start;
      // Dropping start flushes every package in flight.
      vld_q    <= bus.adder_tree_start ? vld_shift[Levels-1:0] : '0;
      node_q   <= node_d;
    end
  end

  // Accumulator
  logic [31:0] sum_q;
  logic        fin_q;

  always_ff @(posedge clk) begin
    if (reset || !bus.adder_tree_start) begin
      sum_q <= 32'h0;
      fin_q <= 1'b0;
    end else if (vld_q[Levels-1]) begin
      sum_q <= fp_add(sum_q, node_q[Nodes-1]);
      fin_q <= 1'b1;
    end else begin
      fin_q <= 1'b0;
    end
  end

  assign bus.sum_out            = sum_q;
  // Both pulses are masked while start is low so a clear never reports a finish.
  assign bus.final_adder_finish = fin_q & bus.adder_tree_start;
  assign bus.tree_finish        = vld_q[Levels-1] & bus.adder_tree_start;

  // Multiples store
  logic [31:0] mem_q [fifo_depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (bus.fifo_write_enable && (bus.fifo_write_address < DepthA)) begin
      mem_q[bus.fifo_write_address[Aw-1:0]] <= bus.fifo_write_data;
    end
  end

  assign bus.fifo_read_data = (bus.fifo_read_address < DepthA) ?
                              mem_q[bus.fifo_read_address[Aw-1:0]] : 32'h0;

endmodule

// File: tb/tb_eight_organizer_control_row.sv
// Self-checking bench for eight_organizer_control_row: table-driven demux, package and
// FIFO vectors plus hand-written multi-cycle sequences; package sums are checked through
// an expected-value queue popped on every final_adder_finish pulse.
module tb_eight_organizer_control_row;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  eight_organizer_control_row_if #(.no_of_units(8), .element_width(32)) bus ();

  eight_organizer_control_row #(
    .no_of_units  (8),
    .element_width(32),
    .fifo_depth   (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         sel;
    logic [255:0] exp_out;
  } dmx_vec_t;

  typedef struct {
    logic [31:0] lane [8];
    logic [31:0] exp_sum;
  } pkt_vec_t;

  typedef struct {
    logic        we;
    logic [12:0] waddr;
    logic [31:0] wdata;
    logic [12:0] raddr;
    logic [31:0] exp_rd;
  } fifo_vec_t;

  dmx_vec_t    dv [3];
  pkt_vec_t    pv [8];
  fifo_vec_t   fv [9];
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic [31:0] lanes_tmp [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pack(input logic [31:0] l [8]);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = l[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    bus.adder_tree_start = 1'b0;
    step();
    bus.adder_tree_start = 1'b1;
  endtask

  task automatic send(input logic [31:0] l [8]);
    bus.package_in    = pack(l);
    bus.package_valid = 1'b1;
    step();
    bus.package_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check(name, 256'(exp_q.size()), 256'd0);
    exp_q.delete();
    repeat (3) step();
  endtask

  // Scoreboard: every absorbed package must match the oldest expected sum.
  always @(negedge clk) begin
    if (!reset && bus.final_adder_finish) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish actual=%0h required=no_pulse", bus.sum_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sum_out", 256'(bus.sum_out), 256'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;

    dv[0] = '{128'h3F800000_3F800000_3F800000_3F800000, 1'b0,
              {128'h3F800000_3F800000_3F800000_3F800000, 128'h0}};
    dv[1] = '{128'h3F800000_3F800000_3F800000_3F800000, 1'b1,
              {128'h0, 128'h3F800000_3F800000_3F800000_3F800000}};
    dv[2] = '{128'h01234567_89ABCDEF_DEADBEEF_00C0FFEE, 1'b0,
              {128'h01234567_89ABCDEF_DEADBEEF_00C0FFEE, 128'h0}};

    pv[0].lane = '{default: 32'h3F800000};
    pv[0].exp_sum = 32'h41000000;
    pv[1].lane = '{default: 32'h40000000};
    pv[1].exp_sum = 32'h41800000;
    pv[2].lane = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                   32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
    pv[2].exp_sum = 32'h00000000;
    pv[3].lane = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    pv[3].exp_sum = 32'h42100000;
    pv[4].lane = '{default: 32'hC0000000};
    pv[4].exp_sum = 32'hC1800000;
    pv[5].lane = '{32'h3F800000, 32'h33800001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`ifdef ORGANIZER_ROUND_NEAREST_EN
    pv[5].exp_sum = 32'h3F800001;
`else
    pv[5].exp_sum = 32'h3F800000;
`endif
    pv[6].lane = '{32'h7F800000, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pv[6].exp_sum = 32'h7FC00000;
    pv[7].lane = '{default: 32'h00000001};
    pv[7].exp_sum = 32'h00000000;

    fv[0] = '{1'b1, 13'd3,    32'd5,          13'd3,  32'd0};
    fv[1] = '{1'b1, 13'd12,   32'd7,          13'd3,  32'd5};
    fv[2] = '{1'b0, 13'd0,    32'd0,          13'd12, 32'd0};
    fv[3] = '{1'b1, 13'd9,    32'hDEADBEEF,   13'd9,  32'd0};
    fv[4] = '{1'b1, 13'd10,   32'h1234,       13'd9,  32'hDEADBEEF};
    fv[5] = '{1'b0, 13'd0,    32'd0,          13'd10, 32'd0};
    fv[6] = '{1'b1, 13'd3,    32'h55,         13'd3,  32'd5};
    fv[7] = '{1'b0, 13'd0,    32'd0,          13'd3,  32'h55};
    fv[8] = '{1'b1, 13'd8191, 32'd1,          13'd0,  32'd0};

    reset                  = 1'b1;
    bus.demux_in           = '0;
    bus.demux_select       = 1'b0;
    bus.package_in         = '0;
    bus.package_valid      = 1'b0;
    bus.adder_tree_start   = 1'b1;
    bus.fifo_write_enable  = 1'b0;
    bus.fifo_write_address = '0;
    bus.fifo_read_address  = 13'd3;
    bus.fifo_write_data    = '0;
    repeat (2) step();
    @(negedge clk);
    check("reset_sum", 256'(bus.sum_out), 256'h0);
    check("reset_final", 256'(bus.final_adder_finish), 256'h0);
    check("reset_tree", 256'(bus.tree_finish), 256'h0);
    check("reset_fifo", 256'(bus.fifo_read_data), 256'h0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      bus.demux_in     = dv[i].din;
      bus.demux_select = dv[i].sel;
      #2;
      check($sformatf("demux%0d", i), bus.demux_out, dv[i].exp_out);
    end

    // Latency: tree_finish after edge t+3, accumulate at edge t+4.
    clear_acc();
    lanes_tmp = pv[0].lane;
    bus.package_in    = pack(lanes_tmp);
    bus.package_valid = 1'b1;
    exp_q.push_back(32'h41000000);
    @(posedge clk);
    #1;
    bus.package_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("tree_finish_t%0d", k), 256'(bus.tree_finish), 256'(k == 3));
      check($sformatf("final_finish_t%0d", k), 256'(bus.final_adder_finish), 256'(k == 4));
    end
    #1;
    wait_drain("latency_drain");

    for (int i = 0; i < 8; i++) begin
      clear_acc();
      exp_q.push_back(pv[i].exp_sum);
      lanes_tmp = pv[i].lane;
      send(lanes_tmp);
      wait_drain($sformatf("pkt%0d_drain", i));
    end

    // Back-to-back accumulation, then clear and rebuild 16.0 from zero.
    clear_acc();
    lanes_tmp = pv[0].lane;
    exp_q.push_back(32'h41000000);
    exp_q.push_back(32'h41800000);
    bus.package_in    = pack(lanes_tmp);
    bus.package_valid = 1'b1;
    step();
    step();
    bus.package_valid = 1'b0;
    wait_drain("b2b_drain");
    check("b2b_sum", 256'(bus.sum_out), 256'h41800000);
    clear_acc();
    lanes_tmp = pv[1].lane;
    exp_q.push_back(32'h41800000);
    send(lanes_tmp);
    wait_drain("clear_drain");
    check("clear_sum", 256'(bus.sum_out), 256'h41800000);

    // Accumulator overflow saturates to +Inf.
    clear_acc();
    lanes_tmp = '{32'h7F000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_q.push_back(32'h7F000000);
    exp_q.push_back(32'h7F800000);
    send(lanes_tmp);
    send(lanes_tmp);
    wait_drain("ovf_drain");

    // Start dropped while a package is in flight: it must never reach the accumulator.
    clear_acc();
    lanes_tmp = pv[0].lane;
    send(lanes_tmp);
    step();
    clear_acc();
    lanes_tmp = pv[1].lane;
    exp_q.push_back(32'h41800000);
    send(lanes_tmp);
    wait_drain("flush_drain");

    for (int i = 0; i < 9; i++) begin
      bus.fifo_write_enable  = fv[i].we;
      bus.fifo_write_address = fv[i].waddr;
      bus.fifo_write_data    = fv[i].wdata;
      bus.fifo_read_address  = fv[i].raddr;
      @(negedge clk);
      check($sformatf("fifo%0d", i), 256'(bus.fifo_read_data), 256'(fv[i].exp_rd));
      step();
    end
    bus.fifo_write_enable = 1'b0;

    // Reset mid-operation clears the store and the accumulator.
    bus.fifo_read_address = 13'd3;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_fifo", 256'(bus.fifo_read_data), 256'h0);
    check("post_reset_sum", 256'(bus.sum_out), 256'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
